// File: rtl/pipe5_bus_arbiter_if.sv
// Bus bundle for pipe5_bus_arbiter: fetch port, data port and the shared downstream bus.
// slave is the arbiter's view; master is the view of the requesters plus the downstream memory.
interface pipe5_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                i_ren;
   logic [ADDR_W-1:0]   i_addr;
   logic [DATA_W-1:0]   i_rdata;
   logic                i_busy;

   logic                d_ren;
   logic                d_wen;
   logic [ADDR_W-1:0]   d_addr;
   logic [DATA_W-1:0]   d_wdata;
   logic [DATA_W/8-1:0] d_byte_en;
   logic [DATA_W-1:0]   d_rdata;
   logic                d_busy;

   logic                m_ren;
   logic                m_wen;
   logic [ADDR_W-1:0]   m_addr;
   logic [DATA_W-1:0]   m_wdata;
   logic [DATA_W/8-1:0] m_byte_en;
   logic [DATA_W-1:0]   m_rdata;
   logic                m_busy;

   modport slave (
      input  i_ren, i_addr, d_ren, d_wen, d_addr, d_wdata, d_byte_en, m_rdata, m_busy,
      output i_rdata, i_busy, d_rdata, d_busy, m_ren, m_wen, m_addr, m_wdata, m_byte_en
   );

   modport master (
      output i_ren, i_addr, d_ren, d_wen, d_addr, d_wdata, d_byte_en, m_rdata, m_busy,
      input  i_rdata, i_busy, d_rdata, d_busy, m_ren, m_wen, m_addr, m_wdata, m_byte_en
   );
endinterface

// File: rtl/pipe5_bus_arbiter.sv
// Fetch/data arbiter onto one bus: 1-cycle arbitration, grant held until m_busy low, data wins ties.
// Build option PIPE5_ARB_FAIRNESS_EN forces a fetch grant after STARVE_LIMIT data grants.
module pipe5_bus_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic               CLK,
   input  logic               nRST,
   pipe5_bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                w_d_req;
   logic                w_force_i;
   logic [ADDR_W-1:0]   w_m_addr;
   logic [DATA_W-1:0]   w_m_wdata;
   logic [DATA_W/8-1:0] w_m_byte_en;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
      $error("pipe5_bus_arbiter: STARVE_LIMIT must be within 1..15");
   end

   assign w_d_req = bus.d_ren | bus.d_wen;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

`ifdef PIPE5_ARB_FAIRNESS_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] r_starve_cnt;

   assign w_force_i = bus.i_ren && (r_starve_cnt == LIMIT);

   // Counts data completions that overtook a waiting fetch.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_starve_cnt <= '0;
      end else if (r_state == IDLE && (w_next_state == GNT_I || !bus.i_ren)) begin
         r_starve_cnt <= '0;
      end else if (r_state == GNT_D && w_d_req && !bus.m_busy && bus.i_ren
                   && r_starve_cnt < LIMIT) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end
`else
   assign w_force_i = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_force_i)      w_next_state = GNT_I;
            else if (w_d_req)   w_next_state = GNT_D;
            else if (bus.i_ren) w_next_state = GNT_I;
         end
         GNT_I:   if (!bus.i_ren || !bus.m_busy) w_next_state = IDLE;
         GNT_D:   if (!w_d_req   || !bus.m_busy) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Strobes depend only on state and the owner's request, never on m_busy.
   always_comb begin
      bus.m_ren   = 1'b0;
      bus.m_wen   = 1'b0;
      w_m_addr    = '0;
      w_m_wdata   = '0;
      w_m_byte_en = '0;
      bus.i_busy  = 1'b1;
      bus.d_busy  = 1'b1;
      case (r_state)
         GNT_I: begin
            if (bus.i_ren) begin
               bus.m_ren   = 1'b1;
               w_m_addr    = bus.i_addr;
               w_m_byte_en = '1;
               bus.i_busy  = bus.m_busy;
            end
         end
         GNT_D: begin
            if (w_d_req) begin
               bus.m_ren   = bus.d_ren;
               bus.m_wen   = bus.d_wen;
               w_m_addr    = bus.d_addr;
               w_m_wdata   = bus.d_wdata;
               w_m_byte_en = bus.d_byte_en;
               bus.d_busy  = bus.m_busy;
            end
         end
         default: ;
      endcase
   end

   assign bus.m_addr    = w_m_addr;
   assign bus.m_wdata   = w_m_wdata;
   assign bus.m_byte_en = w_m_byte_en;
   assign bus.i_rdata   = bus.m_rdata;
   assign bus.d_rdata   = bus.m_rdata;
endmodule

// File: tb/tb_pipe5_bus_arbiter.sv
// Directed bench for pipe5_bus_arbiter: reset, fetch, tie-break, fairness, wait states, reset mid-grant.
module tb_pipe5_bus_arbiter;
   logic CLK = 1'b0;
   logic nRST;
   int   n_cmp  = 0;
   int   n_fail = 0;

   pipe5_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   pipe5_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_inputs();
      bus.i_ren     = 1'b0;
      bus.i_addr    = '0;
      bus.d_ren     = 1'b0;
      bus.d_wen     = 1'b0;
      bus.d_addr    = '0;
      bus.d_wdata   = '0;
      bus.d_byte_en = '0;
      bus.m_rdata   = '0;
      bus.m_busy    = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] st;
      nRST = 1'b0;
      clear_inputs();
      #2;
      n_cmp++;
      if ({bus.m_ren, bus.m_wen, bus.m_addr, bus.m_wdata, bus.m_byte_en} !== 70'd0) begin
         n_fail++;
         $display("FAIL reset_bus: got ren=%b wen=%b addr=%h wdata=%h be=%h, want all zero",
                  bus.m_ren, bus.m_wen, bus.m_addr, bus.m_wdata, bus.m_byte_en);
      end
      n_cmp++;
      if ({bus.i_busy, bus.d_busy} !== 2'b11) begin
         n_fail++;
         $display("FAIL reset_busy: got i=%b d=%b, want 1 1", bus.i_busy, bus.d_busy);
      end
      repeat (2) @(posedge CLK);
      #1;
      nRST = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge CLK);
         st = {bus.m_ren, bus.m_wen, bus.i_busy, bus.d_busy};
         n_cmp++;
         if (st !== 4'b0011) begin
            n_fail++;
            $display("FAIL reset_idle c%0d: got ren,wen,ib,db=%b, want 0011", c, st);
         end
         next_cycle();
      end
   endtask

   task automatic test_single_fetch();
      bus.i_ren   = 1'b1;
      bus.i_addr  = 32'h200;
      bus.m_busy  = 1'b0;
      bus.m_rdata = 32'hDEADBEEF;
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.i_busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL fetch_c0: got m_ren=%b i_busy=%b, want 0 1", bus.m_ren, bus.i_busy);
      end
      next_cycle();
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.m_wen, bus.m_byte_en} !== 6'b10_1111 || bus.m_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL fetch_c1_bus: got ren=%b wen=%b be=%h addr=%h, want 1 0 f 00000200",
                  bus.m_ren, bus.m_wen, bus.m_byte_en, bus.m_addr);
      end
      n_cmp++;
      if ({bus.i_busy, bus.d_busy} !== 2'b01 || bus.i_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL fetch_c1_resp: got i_busy=%b d_busy=%b rdata=%h, want 0 1 deadbeef",
                  bus.i_busy, bus.d_busy, bus.i_rdata);
      end
      next_cycle();
      bus.i_ren = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.m_wen, bus.i_busy, bus.d_busy} !== 4'b0011) begin
         n_fail++;
         $display("FAIL fetch_c2_idle: got ren=%b wen=%b ib=%b db=%b, want 0 0 1 1",
                  bus.m_ren, bus.m_wen, bus.i_busy, bus.d_busy);
      end
      next_cycle();
   endtask

   task automatic test_fetch_and_write();
      bus.i_ren     = 1'b1;
      bus.i_addr    = 32'h300;
      bus.d_wen     = 1'b1;
      bus.d_addr    = 32'h80;
      bus.d_wdata   = 32'h12345678;
      bus.d_byte_en = 4'h3;
      bus.m_busy    = 1'b0;
      bus.m_rdata   = 32'h55AA55AA;
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.m_wen, bus.i_busy, bus.d_busy} !== 4'b0011) begin
         n_fail++;
         $display("FAIL tie_c0: got ren=%b wen=%b ib=%b db=%b, want 0 0 1 1",
                  bus.m_ren, bus.m_wen, bus.i_busy, bus.d_busy);
      end
      next_cycle();
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.m_wen, bus.m_byte_en} !== 6'b01_0011 || bus.m_addr !== 32'h80
          || bus.m_wdata !== 32'h12345678) begin
         n_fail++;
         $display("FAIL tie_write_bus: got ren=%b wen=%b be=%h addr=%h wdata=%h, want 0 1 3 00000080 12345678",
                  bus.m_ren, bus.m_wen, bus.m_byte_en, bus.m_addr, bus.m_wdata);
      end
      n_cmp++;
      if ({bus.i_busy, bus.d_busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL tie_write_busy: got i_busy=%b d_busy=%b, want 1 0", bus.i_busy, bus.d_busy);
      end
      next_cycle();
      bus.d_wen = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.m_wen, bus.i_busy} !== 3'b001) begin
         n_fail++;
         $display("FAIL tie_c2_idle: got ren=%b wen=%b i_busy=%b, want 0 0 1",
                  bus.m_ren, bus.m_wen, bus.i_busy);
      end
      next_cycle();
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.m_wen, bus.m_byte_en, bus.i_busy} !== 7'b10_1111_0
          || bus.m_addr !== 32'h300 || bus.i_rdata !== 32'h55AA55AA) begin
         n_fail++;
         $display("FAIL tie_fetch: got ren=%b wen=%b be=%h ib=%b addr=%h rdata=%h, want 1 0 f 0 00000300 55aa55aa",
                  bus.m_ren, bus.m_wen, bus.m_byte_en, bus.i_busy, bus.m_addr, bus.i_rdata);
      end
      next_cycle();
      clear_inputs();
      next_cycle();
   endtask

   task automatic test_fairness();
      int d_done   = 0;
      int d_before = -1;
      bit f_seen   = 1'b0;
      bus.i_ren  = 1'b1;
      bus.i_addr = 32'h400;
      bus.d_ren  = 1'b1;
      bus.d_addr = 32'h100;
      bus.m_busy = 1'b0;
      for (int c = 0; c < 50 && !f_seen; c++) begin
         @(negedge CLK);
         if (bus.i_busy === 1'b0) begin
            f_seen   = 1'b1;
            d_before = d_done;
         end
         if (bus.d_busy === 1'b0) d_done++;
         next_cycle();
      end
      bus.i_ren = 1'b0;
      bus.d_ren = 1'b0;
`ifdef PIPE5_ARB_FAIRNESS_EN
      n_cmp++;
      if (f_seen !== 1'b1 || d_before !== 4) begin
         n_fail++;
         $display("FAIL fair_override: got fetch_seen=%0d data_grants_before=%0d, want 1 and 4",
                  f_seen, d_before);
      end
`else
      n_cmp++;
      if (f_seen !== 1'b0) begin
         n_fail++;
         $display("FAIL strict_priority: got fetch grant after %0d data grants, want none in 50 cycles",
                  d_before);
      end
      n_cmp++;
      if (d_done !== 25) begin
         n_fail++;
         $display("FAIL stream_rate: got %0d data completions in 50 cycles, want 25", d_done);
      end
`endif
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.m_wen, bus.i_busy, bus.d_busy} !== 4'b0011) begin
         n_fail++;
         $display("FAIL fair_idle: got ren=%b wen=%b ib=%b db=%b, want 0 0 1 1",
                  bus.m_ren, bus.m_wen, bus.i_busy, bus.d_busy);
      end
      next_cycle();
      next_cycle();
   endtask

   task automatic test_wait_states();
      clear_inputs();
      bus.d_ren   = 1'b1;
      bus.d_addr  = 32'h90;
      bus.m_busy  = 1'b1;
      bus.m_rdata = 32'hCAFEF00D;
      next_cycle();
      for (int k = 1; k <= 3; k++) begin
         @(negedge CLK);
         n_cmp++;
         if ({bus.m_ren, bus.d_busy, bus.i_busy} !== 3'b111 || bus.m_addr !== 32'h90) begin
            n_fail++;
            $display("FAIL wait_c%0d: got ren=%b db=%b ib=%b addr=%h, want 1 1 1 00000090",
                     k, bus.m_ren, bus.d_busy, bus.i_busy, bus.m_addr);
         end
         next_cycle();
      end
      bus.m_busy = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.d_busy} !== 2'b10 || bus.m_addr !== 32'h90
          || bus.d_rdata !== 32'hCAFEF00D) begin
         n_fail++;
         $display("FAIL wait_c4: got ren=%b db=%b addr=%h rdata=%h, want 1 0 00000090 cafef00d",
                  bus.m_ren, bus.d_busy, bus.m_addr, bus.d_rdata);
      end
      next_cycle();
      bus.d_ren = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.d_busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL wait_idle: got ren=%b db=%b, want 0 1", bus.m_ren, bus.d_busy);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_grant();
      clear_inputs();
      bus.d_wen     = 1'b1;
      bus.d_addr    = 32'hA0;
      bus.d_wdata   = 32'h0F0F0F0F;
      bus.d_byte_en = 4'hF;
      bus.m_busy    = 1'b1;
      next_cycle();
      @(negedge CLK);
      n_cmp++;
      if (bus.m_wen !== 1'b1) begin
         n_fail++;
         $display("FAIL rstmid_grant: got m_wen=%b, want 1", bus.m_wen);
      end
      next_cycle();
      #2;
      nRST = 1'b0;
      #1;
      n_cmp++;
      if ({bus.m_wen, bus.m_ren, bus.d_busy} !== 3'b001) begin
         n_fail++;
         $display("FAIL rstmid_async: got wen=%b ren=%b db=%b, want 0 0 1",
                  bus.m_wen, bus.m_ren, bus.d_busy);
      end
      bus.d_wen = 1'b0;
      @(posedge CLK);
      #1;
      nRST = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.m_wen, bus.i_busy, bus.d_busy} !== 4'b0011) begin
         n_fail++;
         $display("FAIL rstmid_idle: got ren=%b wen=%b ib=%b db=%b, want 0 0 1 1",
                  bus.m_ren, bus.m_wen, bus.i_busy, bus.d_busy);
      end
      next_cycle();
      bus.i_ren   = 1'b1;
      bus.i_addr  = 32'h500;
      bus.m_busy  = 1'b0;
      bus.m_rdata = 32'h0BADF00D;
      next_cycle();
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.i_busy} !== 2'b10 || bus.m_addr !== 32'h500
          || bus.i_rdata !== 32'h0BADF00D) begin
         n_fail++;
         $display("FAIL rstmid_fetch: got ren=%b ib=%b addr=%h rdata=%h, want 1 0 00000500 0badf00d",
                  bus.m_ren, bus.i_busy, bus.m_addr, bus.i_rdata);
      end
      next_cycle();
      bus.i_ren = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if ({bus.m_ren, bus.i_busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL rstmid_fetch_done: got ren=%b ib=%b, want 0 1", bus.m_ren, bus.i_busy);
      end
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_fetch_and_write();
      test_fairness();
      test_wait_states();
      test_reset_mid_grant();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
